proto_msg_stack_ctrl: RTL

Nesting controller for the protobuf decode path. Tracks the stack of currently open (embedded) messages and the remaining byte budget of each. Publishes the current dependency path, in the same `{level2, level1, level0}` identifier encoding used for node lookup (e.g. `{00,BB,AA}`), so the downstream field-metadata ROM stage always addresses the correct node. Sequences message entry and exit, and throttles the byte stream while closing messages.

---
 rtl/proto_msg_stack_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/proto_msg_stack_ctrl.sv
// Nesting controller for the protobuf decode path.
// Keeps one identifier and one remaining-byte count per open message level,
// publishes the open identifiers as a packed path for the node-lookup ROM,
// and closes finished levels one per cycle while holding off the byte stream.
module proto_msg_stack_ctrl #(
    parameter int                         NUM_MSG_HIERARCHY = 3,
    parameter int                         IDENTIFIER_SIZE   = 8,
    parameter int                         LEN_WIDTH         = 16,
    parameter logic [IDENTIFIER_SIZE-1:0] ROOT_ID           = 8'hAA
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    input  logic [LEN_WIDTH-1:0]                           root_len,
    input  logic                                           byte_valid,
    output logic                                           byte_ready,
    input  logic                                           push_valid,
    output logic                                           push_ready,
    input  logic [IDENTIFIER_SIZE-1:0]                     push_id,
    input  logic [LEN_WIDTH-1:0]                           push_len,
    output logic [NUM_MSG_HIERARCHY*IDENTIFIER_SIZE-1:0]   path,
    output logic [$clog2(NUM_MSG_HIERARCHY+1)-1:0]         depth,
    output logic                                           busy,
    output logic                                           msg_done,
    output logic [IDENTIFIER_SIZE-1:0]                     done_id,
    output logic                                           overflow_err,
    output logic                                           len_err,
    output logic                                           underrun_err
);

    localparam int DEPTH_W = $clog2(NUM_MSG_HIERARCHY + 1);
    localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(NUM_MSG_HIERARCHY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        POP    = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [DEPTH_W-1:0]         depth_q, depth_d;
    logic [IDENTIFIER_SIZE-1:0] id_q  [NUM_MSG_HIERARCHY];
    logic [IDENTIFIER_SIZE-1:0] id_d  [NUM_MSG_HIERARCHY];
    logic [LEN_WIDTH-1:0]       rem_q [NUM_MSG_HIERARCHY];
    logic [LEN_WIDTH-1:0]       rem_d [NUM_MSG_HIERARCHY];
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [IDENTIFIER_SIZE-1:0] doneId_q, doneId_d;
    logic                       ovfErr_q, ovfErr_d;
    logic                       lenErr_q, lenErr_d;
    logic                       undErr_q, undErr_d;

    logic [LEN_WIDTH-1:0]       topRem;
    logic [LEN_WIDTH-1:0]       parentAfter;
    logic [LEN_WIDTH-1:0]       newTopRem;
    logic [IDENTIFIER_SIZE-1:0] topId;
    logic                       topEmptied;

    // Next-state logic: level bookkeeping, sequencing and sticky error capture.
    // A same-cycle byte is applied to the open levels before a push is judged,
    // so a child can never claim bytes its parent no longer has.
    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        doneId_d    = doneId_q;
        ovfErr_d    = ovfErr_q;
        lenErr_d    = lenErr_q;
        undErr_d    = undErr_q;
        topRem      = '0;
        newTopRem   = '0;
        topId       = '0;
        parentAfter = '0;
        topEmptied  = 1'b0;
        for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
            id_d[i]  = id_q[i];
            rem_d[i] = rem_q[i];
            if (i + 1 == int'(depth_q)) begin
                topRem = rem_q[i];
                topId  = id_q[i];
            end
            if (i + 2 == int'(depth_q)) begin
                newTopRem = rem_q[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                        id_d[i]  = '0;
                        rem_d[i] = '0;
                    end
                    id_d[0]  = ROOT_ID;
                    rem_d[0] = root_len;
                    depth_d  = DEPTH_W'(1);
                    ovfErr_d = 1'b0;
                    lenErr_d = 1'b0;
                    undErr_d = 1'b0;
                    state_d  = (root_len == '0) ? POP : ACTIVE;
                end
            end

            ACTIVE: begin
                parentAfter = topRem - LEN_WIDTH'(byte_valid);
                if (byte_valid) begin
                    for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                        if (i < int'(depth_q)) begin
                            rem_d[i] = rem_q[i] - LEN_WIDTH'(1);
                        end
                    end
                    topEmptied = (topRem == LEN_WIDTH'(1));
                end
                state_d = topEmptied ? POP : ACTIVE;
                if (push_valid) begin
                    if (depth_q == MAX_DEPTH) begin
                        ovfErr_d = 1'b1;
                    end else if (push_len > parentAfter) begin
                        lenErr_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                            if (i == int'(depth_q)) begin
                                id_d[i]  = push_id;
                                rem_d[i] = push_len;
                            end
                        end
                        depth_d = depth_q + DEPTH_W'(1);
                        if (push_len == '0) begin
                            state_d = POP;
                        end
                    end
                end
            end

            POP: begin
                for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                    if (i + 1 == int'(depth_q)) begin
                        id_d[i]  = '0;
                        rem_d[i] = '0;
                    end
                end
                done_d   = 1'b1;
                doneId_d = topId;
                depth_d  = depth_q - DEPTH_W'(1);
                if (depth_q == DEPTH_W'(1)) begin
                    state_d = IDLE;
                end else if (newTopRem == '0) begin
                    state_d = POP;
                end else begin
                    state_d = ACTIVE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (byte_valid && !ready_q) begin
            undErr_d = 1'b1;
        end

        ready_d = (state_d == ACTIVE);
        busy_d  = (state_d != IDLE);
    end

    // State and level registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            depth_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            doneId_q <= '0;
            ovfErr_q <= 1'b0;
            lenErr_q <= 1'b0;
            undErr_q <= 1'b0;
            for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                id_q[i]  <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            doneId_q <= doneId_d;
            ovfErr_q <= ovfErr_d;
            lenErr_q <= lenErr_d;
            undErr_q <= undErr_d;
            for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                id_q[i]  <= id_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end

    // Pack the per-level identifiers into the lookup path, level 0 in the low bits.
    always_comb begin
        path = '0;
        for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
            path[i*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] = id_q[i];
        end
    end

    assign byte_ready   = ready_q;
    assign push_ready   = ready_q;
    assign depth        = depth_q;
    assign busy         = busy_q;
    assign msg_done     = done_q;
    assign done_id      = doneId_q;
    assign overflow_err = ovfErr_q;
    assign len_err      = lenErr_q;
    assign underrun_err = undErr_q;

endmodule
